// File: rtl/sdram_port_arb_if.sv
// Bus bundle between two requester ports, the arbiter and the SDRAM controller.
// slave = arbiter view, master = requester/controller (environment) view.
interface sdram_port_arb_if #(
    parameter int ADDR_W = 24
);
    logic              sdram_init_done;
    logic              p0_req,   p1_req;
    logic              p0_we,    p1_we;
    logic [ADDR_W-1:0] p0_addr,  p1_addr;
    logic [9:0]        p0_burst, p1_burst;
    logic              p0_grant, p1_grant;
    logic              p0_done,  p1_done;
    logic              sdram_wr_req, sdram_rd_req;
    logic              sdram_wr_ack, sdram_rd_ack;
    logic [ADDR_W-1:0] sdram_addr;
    logic [9:0]        sdram_wr_burst, sdram_rd_burst;
    logic              ack_err;

    modport slave (
        input  sdram_init_done, p0_req, p1_req, p0_we, p1_we,
               p0_addr, p1_addr, p0_burst, p1_burst,
               sdram_wr_ack, sdram_rd_ack,
        output p0_grant, p1_grant, p0_done, p1_done,
               sdram_wr_req, sdram_rd_req, sdram_addr,
               sdram_wr_burst, sdram_rd_burst, ack_err
    );

    modport master (
        output sdram_init_done, p0_req, p1_req, p0_we, p1_we,
               p0_addr, p1_addr, p0_burst, p1_burst,
               sdram_wr_ack, sdram_rd_ack,
        input  p0_grant, p1_grant, p0_done, p1_done,
               sdram_wr_req, sdram_rd_req, sdram_addr,
               sdram_wr_burst, sdram_rd_burst, ack_err
    );
endinterface

// File: rtl/sdram_port_arb.sv
// Two-port round-robin arbiter in front of an SDRAM controller.
// One transfer in flight: select port, request controller, count data-phase
// acks, pulse done. Ack count is checked against the clamped burst (ack_err).
module sdram_port_arb #(
    parameter int         ADDR_W       = 24,
    parameter logic [9:0] MAX_WR_BURST = 10'd512,
    parameter logic [9:0] MAX_RD_BURST = 10'd256
) (
    input  logic             clk,
    input  logic             rst,
    sdram_port_arb_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

    // Wide enough that an ack stream longer than any legal burst still
    // registers as a mismatch; saturates instead of wrapping.
    localparam int CNT_W = 16;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;     // preferred port when both request
    logic              sel_q, sel_d;     // port being served
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]        wr_burst_q, wr_burst_d;
    logic [9:0]        rd_burst_q, rd_burst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              any_req, pick, req_we, ack;
    logic [ADDR_W-1:0] req_addr;
    logic [9:0]        req_burst, clamped;
    logic [CNT_W-1:0]  cnt_inc, cnt_exp;

    // Candidate selection, burst clamp and ack bookkeeping helpers
    always_comb begin
        any_req   = bus.p0_req | bus.p1_req;
        // a lone requester wins regardless of the pointer
        pick      = (bus.p0_req && bus.p1_req) ? ptr_q : bus.p1_req;
        req_we    = pick ? bus.p1_we    : bus.p0_we;
        req_addr  = pick ? bus.p1_addr  : bus.p0_addr;
        req_burst = pick ? bus.p1_burst : bus.p0_burst;
        clamped   = req_burst;
        if (req_burst == 10'd0)
            clamped = 10'd1;
        else if (req_we && (req_burst > MAX_WR_BURST))
            clamped = MAX_WR_BURST;
        else if (!req_we && (req_burst > MAX_RD_BURST))
            clamped = MAX_RD_BURST;
        // only the ack of the selected direction matters
        ack     = we_q ? bus.sdram_wr_ack : bus.sdram_rd_ack;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        // controller write acks span burst-1 data-phase cycles
        cnt_exp = we_q ? (CNT_W'(wr_burst_q) - CNT_W'(1)) : CNT_W'(rd_burst_q);
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        we_d       = we_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wr_burst_d = wr_burst_q;
        rd_burst_d = rd_burst_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.sdram_init_done && any_req) begin
                    sel_d      = pick;
                    we_d       = req_we;
                    addr_d     = req_addr;
                    wr_burst_d = req_we ? clamped : 10'd0;
                    rd_burst_d = req_we ? 10'd0 : clamped;
                    cnt_d      = '0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (ack) begin
                    cnt_d   = cnt_inc;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (ack) begin
                    cnt_d = cnt_inc;
                end else begin
                    if (cnt_q != cnt_exp) err_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ptr_d   = ~sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= 1'b0;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wr_burst_q <= '0;
            rd_burst_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wr_burst_q <= wr_burst_d;
            rd_burst_q <= rd_burst_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs decoded straight from registered state
    logic busy;
    assign busy               = (state_q == S_REQ) || (state_q == S_XFER);
    assign bus.p0_grant       = busy && !sel_q;
    assign bus.p1_grant       = busy &&  sel_q;
    assign bus.p0_done        = (state_q == S_DONE) && !sel_q;
    assign bus.p1_done        = (state_q == S_DONE) &&  sel_q;
    assign bus.sdram_wr_req   = (state_q == S_REQ) &&  we_q;
    assign bus.sdram_rd_req   = (state_q == S_REQ) && !we_q;
    assign bus.sdram_addr     = addr_q;
    assign bus.sdram_wr_burst = wr_burst_q;
    assign bus.sdram_rd_burst = rd_burst_q;
    assign bus.ack_err        = err_q;
endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: scoreboard of expected grants filled
// when requests are driven, drained when the arbiter grants a port.
module tb_sdram_port_arb;
    localparam int TMO = 200;

    typedef struct {
        int          port;
        logic        we;
        logic [23:0] addr;
        logic [9:0]  wrb;
        logic [9:0]  rdb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic err_exp = 1'b0;
    exp_t sb[$];

    sdram_port_arb_if #(.ADDR_W(24)) bus ();
    sdram_port_arb #(.ADDR_W(24)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] clamp(input logic we, input logic [9:0] b);
        if (b == 10'd0) return 10'd1;
        if (we && b > 10'd512) return 10'd512;
        if (!we && b > 10'd256) return 10'd256;
        return b;
    endfunction

    task automatic push_exp(input int port, input logic we, input logic [23:0] addr, input logic [9:0] b);
        exp_t e;
        e.port = port; e.we = we; e.addr = addr;
        e.wrb  = we ? clamp(we, b) : 10'd0;
        e.rdb  = we ? 10'd0 : clamp(we, b);
        sb.push_back(e);
    endtask

    task automatic req(input int port, input logic we, input logic [23:0] addr, input logic [9:0] b);
        if (port == 0) begin
            bus.p0_we = we; bus.p0_addr = addr; bus.p0_burst = b; bus.p0_req = 1'b1;
        end else begin
            bus.p1_we = we; bus.p1_addr = addr; bus.p1_burst = b; bus.p1_req = 1'b1;
        end
        push_exp(port, we, addr, b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {bus.p0_grant, bus.p1_grant, bus.p0_done, bus.p1_done,
                        bus.sdram_wr_req, bus.sdram_rd_req, bus.ack_err}, 0);
        chk("rst_addr", bus.sdram_addr, 0);
        chk("rst_bursts", {bus.sdram_wr_burst, bus.sdram_rd_burst}, 0);
        rst = 1'b0;
        err_exp = 1'b0;
        sb.delete();
        @(negedge clk);
    endtask

    // Wait for a grant, check it against the scoreboard, play the
    // controller ack stream, then check the done pulse and ack_err.
    task automatic serve(input int nack, input int gap, input bit drop_req);
        exp_t e;
        int   t;
        logic [9:0] bc;
        t = 0;
        while (!(bus.p0_grant || bus.p1_grant) && t < TMO) begin
            @(negedge clk); t++;
        end
        if (t >= TMO) begin chk("grant_timeout", 1, 0); return; end
        if (sb.size() == 0) begin chk("sb_empty", 1, 0); return; end
        e = sb.pop_front();
        chk("grant_port", {bus.p1_grant, bus.p0_grant}, (e.port == 1) ? 2 : 1);
        chk("sdram_addr", bus.sdram_addr, e.addr);
        chk("wr_burst", bus.sdram_wr_burst, e.wrb);
        chk("rd_burst", bus.sdram_rd_burst, e.rdb);
        chk("req_dir", {bus.sdram_wr_req, bus.sdram_rd_req}, e.we ? 2 : 1);
        if (drop_req) begin bus.p0_req = 1'b0; bus.p1_req = 1'b0; end
        // opposite-direction ack must be ignored while waiting
        if (e.we) bus.sdram_rd_ack = 1'b1; else bus.sdram_wr_ack = 1'b1;
        repeat (gap) @(negedge clk);
        chk("req_held", {bus.sdram_wr_req, bus.sdram_rd_req}, e.we ? 2 : 1);
        bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0;
        for (int i = 0; i < nack; i++) begin
            if (e.we) bus.sdram_wr_ack = 1'b1; else bus.sdram_rd_ack = 1'b1;
            @(negedge clk);
            if (i == 0) chk("req_drop", {bus.sdram_wr_req, bus.sdram_rd_req}, 0);
        end
        bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0;
        @(negedge clk);
        bc = e.we ? e.wrb : e.rdb;
        if (nack != (e.we ? int'(bc) - 1 : int'(bc))) err_exp = 1'b1;
        chk("done_pulse", {bus.p1_done, bus.p0_done}, (e.port == 1) ? 2 : 1);
        chk("grant_off", {bus.p1_grant, bus.p0_grant}, 0);
        chk("ack_err", bus.ack_err, err_exp);
        @(negedge clk);
        chk("done_once", {bus.p1_done, bus.p0_done}, 0);
    endtask

    initial begin
        logic bad;
        bus.sdram_init_done = 1'b0;
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        bus.p0_we = 1'b0; bus.p1_we = 1'b0;
        bus.p0_addr = '0; bus.p1_addr = '0;
        bus.p0_burst = '0; bus.p1_burst = '0;
        bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0;
        do_reset();

        // no service before init, then grant on the following cycle
        req(0, 1'b1, 24'h000100, 10'd256);
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            bad |= bus.p0_grant | bus.p1_grant | bus.sdram_wr_req | bus.sdram_rd_req;
        end
        chk("no_init_quiet", bad, 0);
        bus.sdram_init_done = 1'b1;
        @(negedge clk);
        chk("init_grant", bus.p0_grant, 1);
        serve(255, 3, 1'b0);
        bus.p0_req = 1'b0;

        // clamps
        req(1, 1'b0, 24'h00A000, 10'd300); serve(256, 1, 1'b0); bus.p1_req = 1'b0;
        req(1, 1'b0, 24'h00A100, 10'd0);   serve(1, 0, 1'b0);   bus.p1_req = 1'b0;
        req(0, 1'b1, 24'hFFFFF0, 10'd700); serve(511, 0, 1'b0); bus.p0_req = 1'b0;

        // short ack stream -> sticky error survives a good transfer
        req(1, 1'b0, 24'h123456, 10'd256); serve(100, 2, 1'b0); bus.p1_req = 1'b0;
        req(0, 1'b0, 24'h000040, 10'd4);   serve(4, 0, 1'b0);   bus.p0_req = 1'b0;

        // requester drops mid-transfer; done still pulses
        req(0, 1'b0, 24'h000080, 10'd8);   serve(8, 2, 1'b1);

        // alternation with both ports continuously requesting
        do_reset();
        req(0, 1'b1, 24'h0000AA, 10'd16);
        req(1, 1'b0, 24'h0000BB, 10'd32);
        push_exp(0, 1'b1, 24'h0000AA, 10'd16);
        push_exp(1, 1'b0, 24'h0000BB, 10'd32);
        serve(15, 0, 1'b0);
        serve(32, 1, 1'b0);
        serve(15, 2, 1'b0);
        serve(32, 0, 1'b0);
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        chk("sb_drained", sb.size(), 0);

        // reset in XFER aborts without done
        req(1, 1'b1, 24'h00C0DE, 10'd64);
        void'(sb.pop_front());
        repeat (3) @(negedge clk);
        chk("abort_grant", bus.p1_grant, 1);
        bus.sdram_wr_ack = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.sdram_wr_ack = 1'b0;
        bus.p1_req = 1'b0;
        @(negedge clk);
        chk("abort_ctl", {bus.p0_grant, bus.p1_grant, bus.p0_done, bus.p1_done,
                          bus.sdram_wr_req, bus.sdram_rd_req, bus.ack_err}, 0);
        chk("abort_data", {bus.sdram_addr, bus.sdram_wr_burst, bus.sdram_rd_burst}, 0);
        rst = 1'b0;
        err_exp = 1'b0;
        @(negedge clk);
        chk("abort_no_done", {bus.p1_done, bus.p0_done}, 0);
        req(1, 1'b0, 24'h00BEEF, 10'd10);
        serve(10, 1, 1'b0);
        bus.p1_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 Parameter ADDR_W, default 24, width of SDRAM word address.
REQ-002 Parameter MAX_WR_BURST, default 10'd512, largest permitted write burst.
REQ-003 Parameter MAX_RD_BURST, default 10'd256, largest permitted read burst.
REQ-004 clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sdram_init_done  input  1  controller initialisation complete.
REQ-007 p0_req, p1_req  input  1 each  port transfer request, level, held until done.
REQ-008 p0_we, p1_we  input  1 each  1 = write, 0 = read.
REQ-009 p0_addr, p1_addr  input  ADDR_W each  start address.
REQ-010 p0_burst, p1_burst  input  10 each  requested burst length in words.
REQ-011 p0_grant, p1_grant  output  1 each  port owns the SDRAM, from selection to done.
REQ-012 p0_done, p1_done  output  1 each  one-cycle pulse, transfer finished.
REQ-013 sdram_wr_req, sdram_rd_req  output  1 each  request to controller.
REQ-014 sdram_wr_ack, sdram_rd_ack  input  1 each  controller data-phase acknowledge.
REQ-015 sdram_addr  output  ADDR_W  latched address of current transfer.
REQ-016 sdram_wr_burst, sdram_rd_burst  output  10 each  latched, clamped burst length.
REQ-017 ack_err  output  1  sticky: ack count mismatched burst.

Function
REQ-018 FSM states: IDLE, REQ, XFER, DONE; single transfer in flight.
REQ-019 IDLE: no request accepted while sdram_init_done = 0.
REQ-020 IDLE with init done and any pX_req: select port by round-robin; latch we/addr/burst; assert grant; next state REQ.
REQ-021 Round-robin: pointer names preferred port; if only one port requests, it wins regardless of pointer; pointer resets to port 0.
REQ-022 After DONE, pointer set to the non-served port.
REQ-023 Burst clamp at latch: 0 -> 1; write > MAX_WR_BURST -> MAX_WR_BURST; read > MAX_RD_BURST -> MAX_RD_BURST.
REQ-024 REQ: assert sdram_wr_req (we = 1) or sdram_rd_req (we = 0), never both; hold until matching ack seen high, then deassert next cycle; next state XFER.
REQ-025 Acks of the non-selected direction are ignored in all states.
REQ-026 XFER: count cycles with matching ack high (including the first ack seen in REQ); on first cycle ack low, go DONE.
REQ-027 At XFER exit, if ack count != latched burst (for read) or != burst-1 (for write; controller write ack spans burst-1 data-phase cycles plus TRCD/WRITE cycles -- count from first ack to last), set ack_err; cleared only by rst.
REQ-028 DONE: one-cycle pX_done on served port; grant deasserted same cycle; next state IDLE; new selection no earlier than the following cycle.
REQ-029 Requester deasserting pX_req mid-transfer has no effect; transfer completes and done still pulses.
REQ-030 sdram_addr, bursts stable from latch until return to IDLE.
REQ-031 Transfer stall during controller refresh is unbounded; no timeout.

Reset
REQ-032 rst high at any clock: state IDLE, pointer port 0, all grants/dones/sdram_wr_req/sdram_rd_req 0, sdram_addr 0, bursts 0, ack_err 0, ack counter 0.
REQ-033 rst mid-transfer aborts without done pulse; requests drop the cycle after rst sampled.

Verification
REQ-034 init_done = 0, p0_req = 1 for 100 cycles -> no grant, no sdram request; init_done = 1 -> p0_grant next cycle.
REQ-035 p0 write addr 0x000100 burst 256, model acks 255 cycles -> sdram_wr_req until ack, p0_done one pulse, ack_err 0.
REQ-036 p0 and p1 both requesting continuously -> grants alternate p0, p1, p0, p1; no port served twice consecutively.
REQ-037 p1 read burst 300 -> sdram_rd_burst = 256; p1 read burst 0 -> sdram_rd_burst = 1.
REQ-038 rd_ack pulsed only 100 cycles for burst 256 -> ack_err = 1, stays set after next good transfer.
REQ-039 rst asserted during XFER -> next cycle all outputs zero, no done; new request served normally afterwards.
